// File: rtl/thor2023_icache_mem_responder_pkg.sv
// Bus request/response types, responder FSM states and address helpers
// shared by the instruction-cache memory responder and its storage.
package thor2023_icache_mem_responder_pkg;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_STORE,
        CMD_ICACHE_LOAD,
        CMD_DCACHE_LOAD
    } wb_cmd_t;

    typedef struct packed {
        wb_cmd_t      cmd;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [7:0]   tid;
        logic [7:0]   blen;
        logic [15:0]  sel;
        logic [31:0]  padr;
        logic [127:0] dat;
    } wb_cmd_request128_t;

    typedef struct packed {
        logic [7:0]   tid;
        logic         stall;
        logic         next;
        logic         ack;
        logic         rty;
        logic         err;
        logic [3:0]   pri;
        logic [31:0]  adr;
        logic [127:0] dat;
    } wb_cmd_response128_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTY,
        S_RD,
        S_WR,
        S_WAITCYC
    } resp_state_t;

    // Keeps only the address bits above the byte span covered by the RAM.
    function automatic logic [31:0] decode_mask(input int depth_log2);
        return 32'hFFFF_FFFF << (depth_log2 + 4);
    endfunction

    // True when padr falls inside the window starting at base.
    function automatic logic addr_hit(input logic [31:0] padr, input logic [31:0] base,
                                      input int depth_log2);
        return ((padr ^ base) & decode_mask(depth_log2)) == 32'd0;
    endfunction

    // Byte address of a 128-bit word inside the window; the low nibble is always 0.
    function automatic logic [31:0] beat_adr(input logic [31:0] base, input logic [31:0] word,
                                             input int depth_log2);
        return (base & decode_mask(depth_log2)) | (word << 4);
    endfunction

endpackage

// File: rtl/thor2023_icache_mem_responder_if.sv
// Request/response bundle between a bus initiator and the memory responder.
// hold travels with the bus so the fabric can stall the responder.
interface thor2023_icache_mem_responder_if;
    import thor2023_icache_mem_responder_pkg::*;

    wb_cmd_request128_t  wbs_req;
    wb_cmd_response128_t wbs_resp;
    logic                hold;

    modport master (output wbs_req, output hold, input wbs_resp);
    modport slave  (input wbs_req, input hold, output wbs_resp);
endinterface

// File: rtl/thor2023_bram_128x.sv
// Single-port block RAM, 2^DEPTH_LOG2 x 128 bits, per-byte write enables,
// one-cycle registered read (read-before-write on the same address).
module thor2023_bram_128x #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           be,
    input  logic [127:0]          wdat,
    output logic [127:0]          rdat
);

    logic [127:0] mem [2**DEPTH_LOG2];

    // Byte-lane writes and registered read on the shared address.
    // NOTE: storage and read register have no reset so the array maps onto block RAM;
    // contents survive rst_n and rdat is only consumed when a read is known to be pending.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 16; b++) begin
            if (be[b]) begin
                mem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
            end
        end
        rdat <= mem[addr];
    end

endmodule

// File: rtl/thor2023_icache_mem_responder.sv
// Memory-side responder for instruction-cache line loads: decodes its window,
// streams blen+1 beats with next/ack pulses, takes single-beat byte writes,
// and answers rty while hold is raised.
module thor2023_icache_mem_responder
    import thor2023_icache_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'hFFFC0000,
    parameter string       INIT_FILE  = ""
) (
    input logic                            clk,
    input logic                            rst_n,
    thor2023_icache_mem_responder_if.slave bus
);

    localparam int AW = DEPTH_LOG2;
    localparam int HI = DEPTH_LOG2 + 4;

    // This storage has no preload path; contents are loaded over the bus.
    localparam bit unused_init_file = (INIT_FILE != "");

    wb_cmd_request128_t  req;
    wb_cmd_response128_t resp;
    resp_state_t         state;

    logic          selected;
    logic [AW-1:0] word_addr;   // next word to read, or the write target
    logic [AW-1:0] pend_word;   // word whose read data returns this cycle
    logic          pend;        // a read was issued last cycle
    logic [6:0]    issue_cnt;   // beats issued so far, 0..64
    logic [5:0]    blen;
    logic [7:0]    tid;
    logic [15:0]   wr_sel;
    logic [127:0]  wr_dat;
    logic [15:0]   ram_be;
    logic [127:0]  ram_q;

    // Command and the top two burst-length bits carry no meaning here.
    logic unused_req_bits;
    assign unused_req_bits = ^{req.cmd, req.blen[7:6]};

    assign req          = bus.wbs_req;
    assign bus.wbs_resp = resp;
    assign selected     = req.cyc & req.stb & addr_hit(req.padr, BASE, DEPTH_LOG2);

    // RAM writes happen at the edge that leaves WR, together with the write ack.
    assign ram_be = (state == S_WR && blen == 6'd0) ? wr_sel : 16'h0000;

    thor2023_bram_128x #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clk  (clk),
        .addr (word_addr),
        .be   (ram_be),
        .wdat (wr_dat),
        .rdat (ram_q)
    );

    // Responder FSM with registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            resp      <= '0;
            word_addr <= '0;
            pend_word <= '0;
            pend      <= 1'b0;
            issue_cnt <= '0;
            blen      <= '0;
            tid       <= '0;
            wr_sel    <= '0;
            wr_dat    <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle and states override them;
            // with non-blocking assignment the last write in the block wins at the edge.
            resp.ack  <= 1'b0;
            resp.next <= 1'b0;
            resp.rty  <= 1'b0;
            resp.err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (selected) begin
                        tid       <= req.tid;
                        blen      <= req.blen[5:0];
                        word_addr <= req.padr[HI-1:4];
                        wr_sel    <= req.sel;
                        wr_dat    <= req.dat;
                        issue_cnt <= '0;
                        pend      <= 1'b0;
                        if (bus.hold) begin
                            state <= S_RTY;
                        end else if (req.we) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end

                S_RTY: begin
                    resp.rty <= 1'b1;
                    resp.tid <= tid;
                    state    <= S_WAITCYC;
                end

                S_WR: begin
                    resp.ack <= 1'b1;
                    resp.err <= (blen != 6'd0);
                    resp.tid <= tid;
                    resp.adr <= beat_adr(BASE, 32'(word_addr), DEPTH_LOG2);
                    state    <= S_WAITCYC;
                end

                S_RD: begin
                    if (!req.cyc) begin
                        // Initiator gave up: drop the in-flight read and any unsent ack.
                        pend  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        resp.ack <= pend;
                        if (pend) begin
                            resp.dat <= ram_q;
                            resp.tid <= tid;
                            resp.adr <= beat_adr(BASE, 32'(pend_word), DEPTH_LOG2);
                        end
                        if (issue_cnt <= {1'b0, blen}) begin
                            resp.next <= 1'b1;
                            pend      <= 1'b1;
                            pend_word <= word_addr;
                            word_addr <= word_addr + AW'(1);
                            issue_cnt <= issue_cnt + 7'd1;
                        end else begin
                            // The final beat's ack goes out at this edge.
                            pend  <= 1'b0;
                            state <= S_WAITCYC;
                        end
                    end
                end

                S_WAITCYC: begin
                    if (!req.cyc) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thor2023_icache_mem_responder.sv
// Self-checking bench for thor2023_icache_mem_responder: a vector table of
// directed transactions, hand-written abort and reset sequences, and random
// traffic, all judged against a word-array memory model and the cycle rules
// for next/ack/rty/err relative to the accepting edge.
module tb_thor2023_icache_mem_responder;
    import thor2023_icache_mem_responder_pkg::*;

    localparam int           DEPTH  = 1024;
    localparam logic [31:0]  BASE   = 32'hFFFC0000;
    localparam logic [127:0] PAT_A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] PAT_B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] PAT_C  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [127:0] PAT_D  = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    localparam logic [127:0] ONES   = {128{1'b1}};

    typedef struct {
        logic [31:0]  padr;
        logic         we;
        logic [7:0]   blen;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic         hold;
        logic [7:0]   tid;
        int           exp_ack;
        int           exp_next;
        int           exp_rty;
        int           exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [127:0]       model_mem [DEPTH];
    wb_cmd_request128_t req;
    vec_t               vecs [17];

    thor2023_icache_mem_responder_if bus ();

    thor2023_icache_mem_responder #(
        .DEPTH_LOG2 (10),
        .BASE       (BASE),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic in_window(input logic [31:0] padr);
        return padr[31:14] == BASE[31:14];
    endfunction

    function automatic logic [127:0] fill_pattern(input int w);
        logic [31:0] x;
        x = 32'(w);
        return {x * 32'h9E3779B1, ~x, x ^ 32'h5A5A_C3C3, x + 32'h1234_0000};
    endfunction

    // One complete transaction: hold the request for a window of cycles, compare
    // every cycle against the timing rules, then drop cyc and expect silence.
    task automatic run_txn(input vec_t v, input string tag,
                           output int n_ack, output int n_next, output int n_rty, output int n_err);
        bit         hit, rd, wr, rt;
        int         b, w, window;
        logic [3:0] exp_f, got_f;
        hit    = in_window(v.padr);
        b      = int'(v.blen[5:0]);
        w      = int'(v.padr[13:4]);
        rt     = hit && v.hold;
        rd     = hit && !v.hold && !v.we;
        wr     = hit && !v.hold && v.we;
        window = hit ? b + 6 : 20;
        n_ack  = 0;
        n_next = 0;
        n_rty  = 0;
        n_err  = 0;

        req      = '0;
        req.cmd  = v.we ? CMD_STORE : CMD_ICACHE_LOAD;
        req.cyc  = 1'b1;
        req.stb  = 1'b1;
        req.we   = v.we;
        req.tid  = v.tid;
        req.blen = v.blen;
        req.sel  = v.sel;
        req.padr = v.padr;
        req.dat  = v.dat;
        bus.wbs_req = req;
        bus.hold    = v.hold;

        for (int i = 0; i < window; i++) begin
            @(posedge clk);
            #1;
            exp_f = {(wr && i == 1) || (rd && i >= 2 && i <= b + 2),
                     rd && i >= 1 && i <= b + 1,
                     rt && i == 1,
                     wr && b != 0 && i == 1};
            got_f = {bus.wbs_resp.ack, bus.wbs_resp.next, bus.wbs_resp.rty, bus.wbs_resp.err};
            check($sformatf("%s c%0d ack/next/rty/err", tag, i), 128'(got_f), 128'(exp_f));
            n_ack  += int'(got_f[3]);
            n_next += int'(got_f[2]);
            n_rty  += int'(got_f[1]);
            n_err  += int'(got_f[0]);
            if (rd && exp_f[3]) begin
                int k;
                k = (w + i - 2) % DEPTH;
                check($sformatf("%s c%0d dat", tag, i), bus.wbs_resp.dat, model_mem[k]);
                check($sformatf("%s c%0d adr", tag, i), 128'(bus.wbs_resp.adr),
                      128'(BASE + 32'(k) * 32'd16));
                check($sformatf("%s c%0d tid", tag, i), 128'(bus.wbs_resp.tid), 128'(v.tid));
            end
        end

        if (wr && b == 0) begin
            for (int j = 0; j < 16; j++) begin
                if (v.sel[j]) model_mem[w][j*8 +: 8] = v.dat[j*8 +: 8];
            end
        end

        req.cyc = 1'b0;
        req.stb = 1'b0;
        bus.wbs_req = req;
        bus.hold    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            got_f = {bus.wbs_resp.ack, bus.wbs_resp.next, bus.wbs_resp.rty, bus.wbs_resp.err};
            check($sformatf("%s after cyc drop %0d pulses", tag, i), 128'(got_f), 128'(4'b0000));
        end
    endtask

    initial begin
        int   na, nn, nr, ne;
        vec_t v;

        // padr, we, blen, sel, dat, hold, tid, exp ack/next/rty/err
        vecs[0]  = '{32'hFFFC0040, 1'b1, 8'd0,   16'hFFFF, PAT_A,  1'b0, 8'h01, 1, 0, 0, 0};
        vecs[1]  = '{32'hFFFC0050, 1'b1, 8'd0,   16'hFFFF, PAT_B,  1'b0, 8'h02, 1, 0, 0, 0};
        vecs[2]  = '{32'hFFFC0080, 1'b1, 8'd0,   16'hFFFF, 128'd0, 1'b0, 8'h03, 1, 0, 0, 0};
        vecs[3]  = '{32'hFFFC3FF0, 1'b1, 8'd0,   16'hFFFF, PAT_C,  1'b0, 8'h04, 1, 0, 0, 0};
        vecs[4]  = '{32'hFFFC0000, 1'b1, 8'd0,   16'hFFFF, PAT_D,  1'b0, 8'h05, 1, 0, 0, 0};
        vecs[5]  = '{32'hFFFC0040, 1'b0, 8'd1,   16'h0000, 128'd0, 1'b0, 8'h5A, 2, 2, 0, 0};
        vecs[6]  = '{32'hFFFC0040, 1'b0, 8'd1,   16'h0000, 128'd0, 1'b1, 8'h5B, 0, 0, 1, 0};
        vecs[7]  = '{32'hFFFC0040, 1'b0, 8'd1,   16'h0000, 128'd0, 1'b0, 8'h5C, 2, 2, 0, 0};
        vecs[8]  = '{32'hFFFC0080, 1'b1, 8'd0,   16'h00FF, ONES,   1'b0, 8'h06, 1, 0, 0, 0};
        vecs[9]  = '{32'hFFFC0080, 1'b0, 8'd0,   16'h0000, 128'd0, 1'b0, 8'h60, 1, 1, 0, 0};
        vecs[10] = '{32'hFFFC3FF0, 1'b0, 8'd1,   16'h0000, 128'd0, 1'b0, 8'h61, 2, 2, 0, 0};
        vecs[11] = '{32'h00000040, 1'b0, 8'd3,   16'h0000, 128'd0, 1'b0, 8'h62, 0, 0, 0, 0};
        vecs[12] = '{32'hFFFC0040, 1'b1, 8'd2,   16'hFFFF, ONES,   1'b0, 8'h07, 1, 0, 0, 1};
        vecs[13] = '{32'hFFFC0040, 1'b0, 8'd0,   16'h0000, 128'd0, 1'b0, 8'h63, 1, 1, 0, 0};
        vecs[14] = '{32'hFFFC0048, 1'b0, 8'hC1,  16'h0000, 128'd0, 1'b0, 8'h64, 2, 2, 0, 0};
        vecs[15] = '{32'hFFFC3E80, 1'b0, 8'd63,  16'h0000, 128'd0, 1'b0, 8'h65, 64, 64, 0, 0};
        vecs[16] = '{32'hFFFC4000, 1'b0, 8'd0,   16'h0000, 128'd0, 1'b0, 8'h66, 0, 0, 0, 0};

        // Reset state.
        rst_n       = 1'b0;
        req         = '0;
        bus.wbs_req = req;
        bus.hold    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset: response all zero", 128'(bus.wbs_resp == '0), 128'(1'b1));
        check("reset: fsm idle", 128'(dut.state), 128'(S_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after reset release: response all zero", 128'(bus.wbs_resp == '0), 128'(1'b1));

        // Give every RAM word a known value through the write path.
        for (int w = 0; w < DEPTH; w++) begin
            v = '{BASE + 32'(w) * 32'd16, 1'b1, 8'd0, 16'hFFFF, fill_pattern(w), 1'b0, 8'(w),
                  1, 0, 0, 0};
            run_txn(v, "preload", na, nn, nr, ne);
        end

        // Directed vectors.
        for (int t = 0; t < 17; t++) begin
            run_txn(vecs[t], $sformatf("vec%0d", t), na, nn, nr, ne);
            check($sformatf("vec%0d ack count", t),  128'(na), 128'(vecs[t].exp_ack));
            check($sformatf("vec%0d next count", t), 128'(nn), 128'(vecs[t].exp_next));
            check($sformatf("vec%0d rty count", t),  128'(nr), 128'(vecs[t].exp_rty));
            check($sformatf("vec%0d err count", t),  128'(ne), 128'(vecs[t].exp_err));
        end
        check("half-written word 8", model_mem[8], {64'd0, {64{1'b1}}});

        // Abort: blen=3, drop cyc right after the second next is seen.
        begin
            int  nseen, acks_after, nexts_after, since;
            bit  dropped, idle_seen;
            nseen = 0; acks_after = 0; nexts_after = 0; since = 0;
            dropped = 1'b0; idle_seen = 1'b0;
            req      = '0;
            req.cmd  = CMD_ICACHE_LOAD;
            req.cyc  = 1'b1;
            req.stb  = 1'b1;
            req.tid  = 8'h77;
            req.blen = 8'd3;
            req.padr = 32'hFFFC0040;
            bus.wbs_req = req;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (dropped) begin
                    acks_after  += int'(bus.wbs_resp.ack);
                    nexts_after += int'(bus.wbs_resp.next);
                    since++;
                    if (since <= 2 && dut.state == S_IDLE) idle_seen = 1'b1;
                end else begin
                    if (bus.wbs_resp.next) nseen++;
                    if (bus.wbs_resp.ack)
                        check("abort beat dat", bus.wbs_resp.dat, model_mem[4 + i - 2]);
                    if (nseen == 2) begin
                        req.cyc = 1'b0;
                        req.stb = 1'b0;
                        bus.wbs_req = req;
                        dropped = 1'b1;
                    end
                end
            end
            check("abort: cyc dropped after second next", 128'(dropped), 128'(1'b1));
            check("abort: acks after drop", 128'(acks_after), 128'(0));
            check("abort: nexts after drop", 128'(nexts_after), 128'(0));
            check("abort: idle within 2 cycles", 128'(idle_seen), 128'(1'b1));
        end
        run_txn(vecs[7], "after abort", na, nn, nr, ne);
        check("after abort ack count", 128'(na), 128'(2));

        // Reset pulse in the middle of an 8-beat burst.
        req      = '0;
        req.cmd  = CMD_ICACHE_LOAD;
        req.cyc  = 1'b1;
        req.stb  = 1'b1;
        req.tid  = 8'h33;
        req.blen = 8'd7;
        req.padr = 32'hFFFC0040;
        bus.wbs_req = req;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid-burst: next high before reset", 128'(bus.wbs_resp.next), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check("mid-burst reset: response cleared at once", 128'(bus.wbs_resp == '0), 128'(1'b1));
        check("mid-burst reset: dat cleared", bus.wbs_resp.dat, 128'd0);
        req.cyc = 1'b0;
        req.stb = 1'b0;
        bus.wbs_req = req;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after mid-burst reset: fsm idle", 128'(dut.state), 128'(S_IDLE));
        run_txn(vecs[5], "ram kept across reset", na, nn, nr, ne);
        check("ram kept across reset ack count", 128'(na), 128'(2));

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            int kind;
            kind   = $urandom_range(0, 9);
            v      = '{32'd0, 1'b0, 8'd0, 16'h0000, 128'd0, 1'b0, 8'($urandom), 0, 0, 0, 0};
            v.padr = {BASE[31:14], 10'($urandom_range(0, DEPTH - 1)), 4'($urandom)};
            if (kind <= 4) begin
                v.blen = {2'($urandom), 6'($urandom_range(0, 15))};
                if (kind == 4) v.blen[5:0] = 6'd63;
            end else if (kind <= 6) begin
                v.we  = 1'b1;
                v.sel = 16'($urandom);
                v.dat = {$urandom, $urandom, $urandom, $urandom};
            end else if (kind == 7) begin
                v.hold = 1'b1;
                v.we   = 1'($urandom);
            end else if (kind == 8) begin
                v.we   = 1'b1;
                v.blen = 8'($urandom_range(1, 63));
                v.sel  = 16'hFFFF;
                v.dat  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                v.padr = $urandom;
                if (in_window(v.padr)) v.padr = v.padr ^ 32'h8000_0000;
            end
            run_txn(v, $sformatf("rand%0d", t), na, nn, nr, ne);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
